// File: rtl/donut_shade_if.sv
// Shade-job bus: start/coords/hit-test results in, dithered pixel and status out.
interface donut_shade_if;
    logic               start;
    logic [1:0]         px_x;
    logic [1:0]         px_y;
    logic               hit;
    logic [15:0]        light;
    logic [1:0]         r;
    logic [1:0]         g;
    logic [1:0]         b;
    logic               valid;
    logic               busy;

    modport master (
        output start, px_x, px_y, hit, light,
        input  r, g, b, valid, busy
    );

    modport slave (
        input  start, px_x, px_y, hit, light,
        output r, g, b, valid, busy
    );
endinterface

// File: rtl/donut_shade.sv
// Shades one ray-march result: waits out the march latency, samples hit/light,
// and emits a 2-bit grey pixel via a 4x4 ordered dither (or the background on a miss).
module donut_shade #(
    parameter int unsigned ITERS       = 8,
    parameter int unsigned LIGHT_SHIFT = 6,
    parameter logic [5:0]  BG          = 6'b000001
) (
    input  logic           clk,
    input  logic           rst,
    donut_shade_if.slave   sh_io
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIGHT_W = 16;
    localparam int unsigned LUM_W   = 6;
    localparam int unsigned DTH_W   = 4;
    localparam int unsigned SUM_W   = 7;
    localparam int unsigned RGB_W   = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARCH = 2'd1;
    localparam logic [1:0] S_SHADE = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                px_x_q, px_x_d;
    logic [1:0]                px_y_q, px_y_d;
    logic                      hit_q, hit_d;
    logic signed [LIGHT_W-1:0] light_q, light_d;
    logic [RGB_W-1:0]          rgb_q, rgb_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;

    logic signed [LIGHT_W-1:0] s_c;
    logic [LUM_W-1:0]          lum_c;
    logic [DTH_W-1:0]          dith_c;
    logic [SUM_W-1:0]          sum_c;
    logic [1:0]                level_c;
    logic [RGB_W-1:0]          shade_c;

    // Intensity scaling and clamp to a 6-bit luminance
    always_comb begin
        s_c = light_q >>> LIGHT_SHIFT;
        if (s_c < 0) begin
            lum_c = '0;
        end else if (s_c > 16'sd63) begin
            lum_c = 6'd63;
        end else begin
            lum_c = s_c[LUM_W-1:0];
        end
    end

    // 4x4 Bayer threshold, rows indexed by y
    always_comb begin
        dith_c = '0;
        case ({px_y_q, px_x_q})
            4'h0: dith_c = 4'd0;
            4'h1: dith_c = 4'd8;
            4'h2: dith_c = 4'd2;
            4'h3: dith_c = 4'd10;
            4'h4: dith_c = 4'd12;
            4'h5: dith_c = 4'd4;
            4'h6: dith_c = 4'd14;
            4'h7: dith_c = 4'd6;
            4'h8: dith_c = 4'd3;
            4'h9: dith_c = 4'd11;
            4'hA: dith_c = 4'd1;
            4'hB: dith_c = 4'd9;
            4'hC: dith_c = 4'd15;
            4'hD: dith_c = 4'd7;
            4'hE: dith_c = 4'd13;
            4'hF: dith_c = 4'd5;
            default: dith_c = '0;
        endcase
    end

    // Quantise (lum + dither) / 16, saturating at 3 since the sum can reach 78
    always_comb begin
        sum_c = SUM_W'(lum_c) + SUM_W'(dith_c);
        if (sum_c >= 7'd48) begin
            level_c = 2'd3;
        end else if (sum_c >= 7'd32) begin
            level_c = 2'd2;
        end else if (sum_c >= 7'd16) begin
            level_c = 2'd1;
        end else begin
            level_c = 2'd0;
        end
        shade_c = hit_q ? {level_c, level_c, level_c} : BG;
    end

    // Next-state: a start in any state restarts the job
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        px_x_d  = px_x_q;
        px_y_d  = px_y_q;
        hit_d   = hit_q;
        light_d = light_q;
        rgb_d   = rgb_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        if (sh_io.start) begin
            px_x_d  = sh_io.px_x;
            px_y_d  = sh_io.px_y;
            cnt_d   = CNT_W'(ITERS);
            busy_d  = 1'b1;
            state_d = S_MARCH;
        end else begin
            case (state_q)
                S_MARCH: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hit_d   = sh_io.hit;
                        light_d = sh_io.light;
                        state_d = S_SHADE;
                    end
                end
                S_SHADE: begin
                    rgb_d   = shade_c;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            px_x_q  <= '0;
            px_y_q  <= '0;
            hit_q   <= 1'b0;
            light_q <= '0;
            rgb_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            px_x_q  <= px_x_d;
            px_y_q  <= px_y_d;
            hit_q   <= hit_d;
            light_q <= light_d;
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sh_io.r     = rgb_q[5:4];
    assign sh_io.g     = rgb_q[3:2];
    assign sh_io.b     = rgb_q[1:0];
    assign sh_io.valid = valid_q;
    assign sh_io.busy  = busy_q;

endmodule

// File: tb/tb_donut_shade.sv
// Directed bench for donut_shade with a job-age reference model checked every cycle.
module tb_donut_shade;

    localparam int ITERS = 8;

    logic clk;
    logic rst;
    donut_shade_if sh ();

    donut_shade #(.ITERS(ITERS), .LIGHT_SHIFT(6), .BG(6'b000001)) dut (
        .clk   (clk),
        .rst   (rst),
        .sh_io (sh)
    );

    int n_cmp = 0;
    int n_err = 0;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_shade(input bit h, input int x, input int y, input int l);
        int s;
        int lum;
        int lvl;
        if (!h) return 6'b000001;
        s   = l >>> 6;
        lum = (s < 0) ? 0 : ((s > 63) ? 63 : s);
        lvl = (lum + bayer[y][x]) / 16;
        if (lvl > 3) lvl = 3;
        return {2'(lvl), 2'(lvl), 2'(lvl)};
    endfunction

    // Reference: a job is just an age counter since its start edge
    bit         live = 1'b0;
    int         age = -1;
    int         cx, cy;
    bit         s_hit;
    int         s_light;
    logic [5:0] e_rgb = '0;
    logic       e_valid = 1'b0;
    logic       e_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            live = 1'b1; age = -1; cx = 0; cy = 0;
            e_rgb = '0; e_valid = 1'b0; e_busy = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (sh.start) begin
                age = 0; cx = int'(sh.px_x); cy = int'(sh.px_y); e_busy = 1'b1;
            end else if (age >= 0) begin
                age++;
                if (age == ITERS) begin
                    s_hit   = sh.hit;
                    s_light = int'($signed(sh.light));
                end else if (age == ITERS + 1) begin
                    e_rgb   = model_shade(s_hit, cx, cy, s_light);
                    e_valid = 1'b1;
                    e_busy  = 1'b0;
                    age     = -1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (live) begin
            chk("valid", 32'(sh.valid), 32'(e_valid));
            chk("busy", 32'(sh.busy), 32'(e_busy));
            chk("rgb", 32'({sh.r, sh.g, sh.b}), 32'(e_rgb));
        end
    end

    // Called right after a negedge; start lands on the next posedge (E0)
    task automatic pulse(input logic [1:0] x, input logic [1:0] y);
        sh.start = 1'b1; sh.px_x = x; sh.px_y = y;
        @(negedge clk);
        sh.start = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] x, input logic [1:0] y, input bit h,
                           input int l, input logic [5:0] exp_rgb);
        bit seen;
        seen = 1'b0;
        sh.hit = h; sh.light = 16'(l);
        pulse(x, y);
        for (int k = 0; k < 20; k++) begin
            if (sh.valid === 1'b1) begin
                chk("latency", 32'(k), 32'(ITERS + 1));
                chk("job_rgb", 32'({sh.r, sh.g, sh.b}), 32'(exp_rgb));
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("valid_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sh.start = 1'b0; sh.px_x = '0; sh.px_y = '0; sh.hit = 1'b0; sh.light = '0;

        chk("pin_1024", 32'(model_shade(1'b1, 0, 0, 1024)), 32'h15);
        chk("pin_1000_y3", 32'(model_shade(1'b1, 0, 3, 1000)), 32'h15);
        chk("pin_4000", 32'(model_shade(1'b1, 0, 3, 4000)), 32'h3f);
        chk("pin_neg", 32'(model_shade(1'b1, 2, 1, -100)), 32'h00);
        chk("pin_miss", 32'(model_shade(1'b0, 1, 1, 4000)), 32'h01);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(sh.busy), 32'd0);
        chk("idle_rgb", 32'({sh.r, sh.g, sh.b}), 32'd0);

        run_job(2'd0, 2'd0, 1'b1, 1024, 6'b010101);
        @(negedge clk);
        run_job(2'd0, 2'd3, 1'b1, 1000, 6'b010101);
        run_job(2'd0, 2'd0, 1'b1, 1000, 6'b000000);
        run_job(2'd0, 2'd3, 1'b1, 4000, 6'b111111);
        run_job(2'd1, 2'd3, 1'b1, -100, 6'b000000);
        @(negedge clk);
        run_job(2'd2, 2'd2, 1'b0, 1234, 6'b000001);
        @(negedge clk);

        // Restart 5 clocks in: first job abandoned
        sh.hit = 1'b1; sh.light = 16'd4000;
        pulse(2'd3, 2'd3);
        repeat (4) @(negedge clk);
        run_job(2'd0, 2'd0, 1'b1, 1024, 6'b010101);
        @(negedge clk);

        // Restart exactly on the sample edge
        sh.hit = 1'b0;
        pulse(2'd2, 2'd1);
        repeat (ITERS - 1) @(negedge clk);
        run_job(2'd1, 2'd2, 1'b1, 1000, 6'b010101);
        @(negedge clk);

        // Restart exactly on the shade edge
        sh.hit = 1'b0;
        pulse(2'd1, 2'd1);
        repeat (ITERS) @(negedge clk);
        run_job(2'd3, 2'd0, 1'b1, 4000, 6'b111111);
        @(negedge clk);

        // Reset 4 clocks after a start: job vanishes, outputs cleared
        sh.hit = 1'b1; sh.light = 16'd1024;
        pulse(2'd0, 2'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_mid_valid", 32'(sh.valid), 32'd0);
        chk("rst_mid_busy", 32'(sh.busy), 32'd0);
        chk("rst_mid_rgb", 32'({sh.r, sh.g, sh.b}), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
